multi_clk_gen: RTL and testbench

Parametrised, fully synchronous multi-channel clock generator built from numerically-controlled oscillators (phase accumulators) running off one fabric clock. It replaces fixed-ratio single-output clock blocks with NB_CH runtime-programmable outputs: per-channel strobes (`tick_o`) and 50%-duty square waves (`clk_o`). It also provides a `locked` indication that deasserts on every reconfiguration. It sits beside the system PLL and feeds LED-driver, SPI and frame-timing logic.

---
 rtl/multi_clk_gen_pkg.sv | 20 ++
 rtl/multi_clk_gen_if.sv | 25 ++
 rtl/clkgen_nco.sv | 58 +++++
 rtl/multi_clk_gen.sv | 131 +++++++++++++
 tb/tb_multi_clk_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_clk_gen_pkg.sv
// multi_clk_gen_pkg
// Shared definitions for the multi-channel NCO clock generator:
//   state_t         - sequencing FSM states (SETTLE, LOCKED, UPDATE)
//   DEF_LOCK_CYCLES - default settle time before `locked` rises
//   ch_w()          - width of the channel-select field (never below 1 bit)
package multi_clk_gen_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int unsigned DEF_LOCK_CYCLES = 16;

  function automatic int unsigned ch_w(input int unsigned nb_ch);
    return (nb_ch > 1) ? $clog2(nb_ch) : 1;
  endfunction

endpackage

// File: rtl/multi_clk_gen_if.sv
// multi_clk_gen_if
// Configuration handshake between a host and multi_clk_gen.
//   cfg_valid - host requests a channel reprogram
//   cfg_ready - generator can accept a request this cycle
//   cfg_ch    - target channel index
//   cfg_inc   - new phase increment for that channel
// Modports: master (host side), slave (generator side).
interface multi_clk_gen_if
  import multi_clk_gen_pkg::*;
#(
  parameter int unsigned NB_CH = 4,
  parameter int unsigned ACC_W = 32
);

  localparam int unsigned CH_W = ch_w(NB_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;

  modport master (output cfg_valid, output cfg_ch, output cfg_inc, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_inc, output cfg_ready);

endinterface

// File: rtl/clkgen_nco.sv
// clkgen_nco
// One numerically-controlled oscillator channel: increment register plus
// phase accumulator, with registered overflow strobe and square-wave output.
// Ports:
//   clk, nrst  - clock, async active-low reset
//   enable     - advance the accumulator this cycle
//   clear      - zero accumulator and outputs (takes priority over enable)
//   load       - write load_inc into the increment register
//   load_inc   - increment value to load
//   tick_o     - one-cycle strobe on accumulator overflow
//   clk_o      - accumulator MSB after the update
module clkgen_nco #(
  parameter int unsigned      ACC_W    = 32,
  parameter logic [ACC_W-1:0] INIT_INC = ACC_W'(1) << (ACC_W - 2)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  output logic             tick_o,
  output logic             clk_o
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  // Extra top bit is the wrap carry.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc    <= '0;
      inc    <= INIT_INC;
      tick_o <= 1'b0;
      clk_o  <= 1'b0;
    end else begin
      if (load) begin
        inc <= load_inc;
      end
      if (clear) begin
        acc    <= '0;
        tick_o <= 1'b0;
        clk_o  <= 1'b0;
      end else if (enable) begin
        acc    <= sum[ACC_W-1:0];
        tick_o <= sum[ACC_W];
        clk_o  <= sum[ACC_W-1];
      end else begin
        // Frozen: clk_o holds its level, no strobes.
        tick_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clk_gen.sv
// multi_clk_gen
// NB_CH runtime-programmable NCO clock outputs from one fabric clock, with a
// lock indication that drops on every reconfiguration.
// Ports:
//   clk, nrst - clock, async active-low reset
//   enable    - all accumulators advance when high
//   cfg       - configuration handshake (multi_clk_gen_if.slave)
//   tick_o    - per-channel overflow strobes
//   clk_o     - per-channel square waves (accumulator MSB)
//   locked    - outputs are stable
// Build option: MULTI_CLK_GEN_PHASE_ALIGN_EN - when defined, an update clears
// every channel so all outputs restart phase-aligned; otherwise only the
// target channel is cleared.
//
// state  | meaning
// SETTLE | counting settle cycles, locked low
// LOCKED | steady state, locked high
// UPDATE | one cycle applying the captured increment, locked low
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int unsigned      NB_CH       = 4,
  parameter int unsigned      ACC_W       = 32,
  parameter logic [ACC_W-1:0] INIT_INC    = ACC_W'(1) << (ACC_W - 2),
  parameter int unsigned      LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  multi_clk_gen_if.slave        cfg,
  output logic [NB_CH-1:0]      tick_o,
  output logic [NB_CH-1:0]      clk_o,
  output logic                  locked
);

  localparam int unsigned CH_W  = ch_w(NB_CH);
  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_inc;
  logic             xfer;
  logic             ch_ok;
  logic             accept;
  logic             upd;

  assign cfg.cfg_ready = (state != UPDATE);
  assign locked        = (state == LOCKED);
  assign upd           = (state == UPDATE);

  // Out-of-range channels still complete the handshake but are dropped here.
  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign ch_ok  = (32'(cfg.cfg_ch) < NB_CH);
  assign accept = xfer && ch_ok;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= SETTLE;
      cnt      <= '0;
      pend_ch  <= '0;
      pend_inc <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        pend_ch  <= cfg.cfg_ch;
        pend_inc <= cfg.cfg_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      SETTLE: begin
        if (accept) begin
          state_nxt = UPDATE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOCKED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (accept) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NB_CH; i++) begin : g_ch
    logic ch_load;
    logic ch_clear;

    assign ch_load = upd && (pend_ch == CH_W'(i));
`ifdef MULTI_CLK_GEN_PHASE_ALIGN_EN
    assign ch_clear = upd;
`else
    assign ch_clear = ch_load;
`endif

    clkgen_nco #(
      .ACC_W   (ACC_W),
      .INIT_INC(INIT_INC)
    ) u_nco (
      .clk     (clk),
      .nrst    (nrst),
      .enable  (enable),
      .clear   (ch_clear),
      .load    (ch_load),
      .load_inc(pend_inc),
      .tick_o  (tick_o[i]),
      .clk_o   (clk_o[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Testbench for multi_clk_gen. Five channels are used so that a 3-bit cfg_ch
// can carry indices (5..7) that lie beyond the last channel.
module tb_multi_clk_gen;
  import multi_clk_gen_pkg::*;

  localparam int unsigned NB = 5;
  localparam int unsigned AW = 32;
  localparam int unsigned LC = 16;
  localparam logic [AW-1:0] INIT = 32'h4000_0000;
  localparam longint unsigned MOD  = 64'd1 << AW;
  localparam longint unsigned HALF = 64'd1 << (AW - 1);
`ifdef MULTI_CLK_GEN_PHASE_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          enable = 1'b0;
  logic [NB-1:0] tick_o;
  logic [NB-1:0] clk_o;
  logic          locked;

  multi_clk_gen_if #(.NB_CH(NB), .ACC_W(AW)) cfg ();

  multi_clk_gen #(
    .NB_CH(NB), .ACC_W(AW), .INIT_INC(INIT), .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .cfg(cfg),
    .tick_o(tick_o), .clk_o(clk_o), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel phase as an integer, settle time as the
  // number of cycles still to wait, and a pending-update flag.
  longint unsigned m_acc [NB];
  longint unsigned m_inc [NB];
  logic [NB-1:0]   m_tick;
  logic [NB-1:0]   m_clk;
  int              m_settle;
  bit              m_pend;
  int              m_pch;
  longint unsigned m_pinc;

  int vectors = 0;
  int errors  = 0;

  task model_reset();
    for (int i = 0; i < NB; i++) begin
      m_acc[i] = 0;
      m_inc[i] = longint'(INIT);
    end
    m_tick   = '0;
    m_clk    = '0;
    m_settle = LC;
    m_pend   = 1'b0;
    m_pch    = 0;
    m_pinc   = 0;
  endtask

  task model_edge();
    bit ready;
    longint unsigned s;
    ready = !m_pend;
    for (int i = 0; i < NB; i++) begin
      if (m_pend && (i == m_pch || ALIGN)) begin
        m_acc[i]  = 0;
        m_tick[i] = 1'b0;
        m_clk[i]  = 1'b0;
        if (i == m_pch) m_inc[i] = m_pinc;
      end else if (enable) begin
        s         = m_acc[i] + m_inc[i];
        m_tick[i] = (s >= MOD);
        m_acc[i]  = s % MOD;
        m_clk[i]  = (m_acc[i] >= HALF);
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    if (m_pend) begin
      m_pend   = 1'b0;
      m_settle = LC;
    end else if (cfg.cfg_valid && ready && int'(cfg.cfg_ch) < NB) begin
      m_pend = 1'b1;
      m_pch  = int'(cfg.cfg_ch);
      m_pinc = longint'(cfg.cfg_inc);
    end else if (m_settle > 0) begin
      m_settle--;
    end
  endtask

  function automatic logic exp_locked();
    return !m_pend && (m_settle == 0);
  endfunction

  function automatic logic exp_ready();
    return !m_pend;
  endfunction

  // Advance one clock: inputs are already stable, model steps at the edge,
  // DUT outputs are then sampled on the falling edge.
  task cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task drive_idle();
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_inc   = '0;
  endtask

  task test_reset();
    enable = 1'b1;
    drive_idle();
    nrst = 1'b0;
    model_reset();
    #12;
    vectors++;
    if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {{(2*NB){1'b0}}, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state tick=%b clk=%b lock=%b rdy=%b want zeros, rdy=1",
               tick_o, clk_o, locked, cfg.cfg_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL reset_run c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=%b r=%b",
                 c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk, exp_locked(), exp_ready());
      end
      if (c == 4 || c == 8) begin
        vectors++;
        if (tick_o !== {NB{1'b1}}) begin
          errors++;
          $display("FAIL reset_tick4 c=%0d got %b exp all ones", c, tick_o);
        end
      end
      if (c == LC - 1 || c == LC) begin
        vectors++;
        if (locked !== (c == LC)) begin
          errors++;
          $display("FAIL reset_lock_time c=%0d got %b exp %b", c, locked, (c == LC));
        end
      end
    end
  endtask

  task test_write_locked();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 3'd1;
    cfg.cfg_inc   = 32'h8000_0000;
    cyc();
    drive_idle();
    vectors++;
    if ({cfg.cfg_ready, locked} !== 2'b00) begin
      errors++;
      $display("FAIL write_update got rdy=%b lock=%b exp rdy=0 lock=0", cfg.cfg_ready, locked);
    end
    for (int c = 1; c <= 22; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL write_run c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=%b r=%b",
                 c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk, exp_locked(), exp_ready());
      end
      if (c == LC || c == LC + 1) begin
        vectors++;
        if (locked !== (c == LC + 1)) begin
          errors++;
          $display("FAIL write_relock c=%0d got %b exp %b", c, locked, (c == LC + 1));
        end
      end
    end
  endtask

  task test_settle_rewrite();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 3'd3;
    cfg.cfg_inc   = 32'h2000_0000;
    cyc();
    drive_idle();
    for (int c = 0; c < 5; c++) cyc();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 3'd0;
    cfg.cfg_inc   = 32'h1000_0000;
    cyc();
    drive_idle();
    for (int c = 1; c <= 20; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL settle_rewrite c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=%b r=%b",
                 c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk, exp_locked(), exp_ready());
      end
      if (c == LC || c == LC + 1) begin
        vectors++;
        if (locked !== (c == LC + 1)) begin
          errors++;
          $display("FAIL settle_relock c=%0d got %b exp %b", c, locked, (c == LC + 1));
        end
      end
    end
  endtask

  task test_bad_ch();
    for (int c = 0; c < 40 && !exp_locked(); c++) cyc();
    for (int k = 5; k <= 7; k++) begin
      cfg.cfg_valid = 1'b1;
      cfg.cfg_ch    = 3'(k);
      cfg.cfg_inc   = $urandom;
      cyc();
      drive_idle();
      for (int c = 0; c < 6; c++) begin
        vectors++;
        if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL bad_ch ch=%0d c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=1 r=1",
                   k, c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk);
        end
        cyc();
      end
    end
  endtask

  task test_zero_and_enable();
    logic [NB-1:0] held;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 3'd2;
    cfg.cfg_inc   = '0;
    cyc();
    drive_idle();
    for (int c = 0; c < 12; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}
          || tick_o[2] !== 1'b0 || clk_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL inc_zero c=%0d got t=%b c=%b l=%b exp t=%b c=%b l=%b",
                 c, tick_o, clk_o, locked, m_tick, m_clk, exp_locked());
      end
    end
    held   = clk_o;
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      vectors++;
      if (tick_o !== '0 || clk_o !== held || clk_o !== m_clk) begin
        errors++;
        $display("FAIL enable_low c=%0d got t=%b c=%b exp t=0 c=%b", c, tick_o, clk_o, m_clk);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL enable_resume c=%0d got t=%b c=%b l=%b exp t=%b c=%b l=%b",
                 c, tick_o, clk_o, locked, m_tick, m_clk, exp_locked());
      end
    end
  endtask

  task test_random();
    for (int c = 0; c < 400; c++) begin
      enable        = ($urandom_range(0, 7) != 0);
      cfg.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg.cfg_ch    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        cfg.cfg_inc = 32'd1 << $urandom_range(24, 31);
      else
        cfg.cfg_inc = $urandom;
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL random c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=%b r=%b",
                 c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk, exp_locked(), exp_ready());
      end
    end
    drive_idle();
    enable = 1'b1;
  endtask

  task test_async_reset();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 3'd4;
    cfg.cfg_inc   = 32'h0800_0000;
    cyc();
    drive_idle();
    for (int c = 0; c < 6; c++) cyc();
    @(posedge clk);
    model_edge();
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {{(2*NB){1'b0}}, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got t=%b c=%b l=%b r=%b exp zeros, rdy=1",
               tick_o, clk_o, locked, cfg.cfg_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      vectors++;
      if ({tick_o, clk_o, locked, cfg.cfg_ready} !== {m_tick, m_clk, exp_locked(), exp_ready()}) begin
        errors++;
        $display("FAIL post_reset c=%0d got t=%b c=%b l=%b r=%b exp t=%b c=%b l=%b r=%b",
                 c, tick_o, clk_o, locked, cfg.cfg_ready, m_tick, m_clk, exp_locked(), exp_ready());
      end
      if (c == 4 || c == 8) begin
        vectors++;
        if (tick_o !== {NB{1'b1}}) begin
          errors++;
          $display("FAIL post_reset_inc c=%0d got %b exp all ones", c, tick_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_locked();
    test_settle_rewrite();
    test_bad_ch();
    test_zero_and_enable();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
